// File: rtl/idct_row_mac.sv
// Single-MAC 8-point 1-D inverse DCT: loads 8 coefficients, then time-multiplexes one multiplier over 64 products.
// Define IDCT_SATURATE_EN to clamp outputs to the OUT_W range; otherwise the result wraps.
module idct_row_mac #(
  parameter int COEF_W  = 12,
  parameter int CONST_W = 13,
  parameter int ACC_W   = 28,
  parameter int OUT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [COEF_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [OUT_W-1:0]  dout,
  output logic [2:0]               dout_idx,
  output logic                     dout_last,
  output logic                     dout_valid,
  input  logic                     dout_ready
);
  localparam int PW = COEF_W + CONST_W;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1024);

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;
  state_t state, state_nx;

  logic [2:0]               u_cnt, x_cnt;
  logic                     fin;
  logic signed [COEF_W-1:0] coef [8];
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext, acc, shifted;
  logic signed [OUT_W-1:0]  res, dout_q;
  logic                     in_hs;

  // C(u,x) folds the phase (2x+1)u mod 32 onto a quarter-wave table of cos(m*pi/16), scaled by 1024.
  function automatic logic signed [CONST_W-1:0] c_rom(input logic [2:0] u, input logic [2:0] x);
    logic [7:0] p;
    logic [5:0] m, f, idx;
    logic signed [CONST_W-1:0] mag;
    p   = {4'd0, x, 1'b1} * {5'd0, u};
    m   = {1'b0, p[4:0]};
    f   = (m > 6'd16) ? 6'd32 - m : m;
    idx = (f > 6'd8) ? 6'd16 - f : f;
    case (idx)
      6'd0:    mag = CONST_W'(1024);
      6'd1:    mag = CONST_W'(1004);
      6'd2:    mag = CONST_W'(946);
      6'd3:    mag = CONST_W'(851);
      6'd4:    mag = CONST_W'(724);
      6'd5:    mag = CONST_W'(569);
      6'd6:    mag = CONST_W'(392);
      6'd7:    mag = CONST_W'(200);
      default: mag = '0;
    endcase
    if (u == 3'd0) return CONST_W'(724);
    return (f > 6'd8) ? -mag : mag;
  endfunction

  assign din_ready  = (state == LOAD);
  assign dout_valid = (state == OUT);
  assign dout       = dout_q;
  assign dout_idx   = x_cnt;
  assign dout_last  = (state == OUT) && (x_cnt == 3'd7);
  assign in_hs      = din_valid && din_ready;

  assign prod     = PW'(coef[u_cnt]) * PW'(c_rom(u_cnt, x_cnt));
  assign prod_ext = ACC_W'(prod);
  assign shifted  = (acc + RND) >>> 11;

`ifdef IDCT_SATURATE_EN
  logic [ACC_W-OUT_W:0] hi;
  assign hi = shifted[ACC_W-1:OUT_W-1];
  always_comb begin
    res = OUT_W'(shifted);
    if (!((&hi) || !(|hi)))
      res = hi[ACC_W-OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  assign res = OUT_W'(shifted);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_hs && u_cnt == 3'd7) state_nx = CALC;
      CALC:    if (fin) state_nx = OUT;
      OUT:     if (dout_ready) state_nx = (x_cnt == 3'd7) ? LOAD : CALC;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else     state <= state_nx;

  // fin marks the extra cycle after u=7 that moves the rounded sum into the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_cnt  <= '0;
      x_cnt  <= '0;
      fin    <= 1'b0;
      acc    <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        LOAD: if (in_hs) begin
          u_cnt <= u_cnt + 3'd1;
          if (u_cnt == 3'd7) x_cnt <= '0;
        end
        CALC: if (fin) begin
          dout_q <= res;
          fin    <= 1'b0;
        end else begin
          acc   <= (u_cnt == 3'd0) ? prod_ext : acc + prod_ext;
          u_cnt <= u_cnt + 3'd1;
          fin   <= (u_cnt == 3'd7);
        end
        OUT: if (dout_ready) x_cnt <= x_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Buffer is only written on input handshakes, so it survives all 8 output passes.
  always_ff @(posedge clk)
    if (in_hs) coef[u_cnt] <= din;

endmodule

// File: tb/tb_idct_row_mac.sv
// Bench for idct_row_mac (OUT_W = 8 so the output range can be exceeded); reference uses real-valued cosines.
module tb_idct_row_mac;
  localparam int OUT_W = 8;
  localparam real PI = 3.14159265358979;
  localparam int DC = 9999;
`ifdef IDCT_SATURATE_EN
  localparam int SAT0 = 127;
`else
  localparam int SAT0 = 31;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [11:0]      din;
  logic                    din_valid, din_ready;
  logic signed [OUT_W-1:0] dout;
  logic [2:0]              dout_idx;
  logic                    dout_last, dout_valid, dout_ready;

  int checks = 0;
  int failures = 0;

  typedef int row_t[8];
  typedef struct {
    string name;
    row_t  f;
    row_t  exp;
  } vec_t;

  idct_row_mac #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_idx(dout_idx), .dout_last(dout_last), .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int crom(input int u, input int x);
    real k, v;
    k = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    v = 2048.0 * k / 2.0 * $cos(real'((2 * x + 1) * u) * PI / 16.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic int model(input row_t f, input int x);
    longint s;
    longint r;
    s = 0;
    for (int u = 0; u < 8; u++) s += longint'(f[u]) * longint'(crom(u, x));
    r = (s + 1024) >>> 11;
`ifdef IDCT_SATURATE_EN
    if (r > 127) r = 127;
    if (r < -128) r = -128;
`else
    r = r & 255;
    if (r > 127) r = r - 256;
`endif
    return int'(r);
  endfunction

  task automatic send_row(input row_t f);
    for (int i = 0; i < 8; i++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (!din_ready && t < 200) begin @(negedge clk); t++; end
      if (!din_ready) check("din_ready_timeout", 0, 1);
      din = f[i][11:0];
      din_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Entered on the negedge after the previous handshake; that negedge counts as 1.
  task automatic recv_row(input string nm, input row_t e, input int nout, input int hold_x,
                          input int max_delay);
    for (int x = 0; x < nout; x++) begin
      int n, d;
      logic signed [OUT_W-1:0] held;
      n = 1;
      while (!dout_valid && n < 40) begin @(negedge clk); n++; end
      check({nm, "_latency"}, n, 10);
      check({nm, "_dout"}, int'(dout), e[x]);
      check({nm, "_idx"}, int'(dout_idx), x);
      check({nm, "_last"}, int'(dout_last), (x == 7) ? 1 : 0);
      if (x == hold_x) begin
        held = dout;
        din_valid = 1'b1;
        din = 12'sh555;
        repeat (5) begin
          @(negedge clk);
          check({nm, "_bp_valid"}, int'(dout_valid), 1);
          check({nm, "_bp_dout"}, int'(dout), int'(held));
          check({nm, "_bp_idx"}, int'(dout_idx), x);
          check({nm, "_bp_din_ready"}, int'(din_ready), 0);
        end
        din_valid = 1'b0;
      end else begin
        d = int'($urandom_range(max_delay, 0));
        repeat (d) @(negedge clk);
      end
      dout_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dout_ready = 1'b0;
      if (x == 7) check({nm, "_din_ready_next"}, int'(din_ready), 1);
    end
  endtask

  initial begin
    vec_t tab[5];
    row_t e, f, z;

    tab[0].name = "dc";     tab[0].f = '{64, 0, 0, 0, 0, 0, 0, 0};
    tab[0].exp  = '{23, 23, 23, 23, 23, 23, 23, 23};
    tab[1].name = "neg_dc"; tab[1].f = '{-64, 0, 0, 0, 0, 0, 0, 0};
    tab[1].exp  = '{-23, -23, -23, -23, -23, -23, -23, -23};
    tab[2].name = "f1";     tab[2].f = '{0, 100, 0, 0, 0, 0, 0, 0};
    tab[2].exp  = '{49, 42, 28, 10, -10, -28, -42, -49};
    tab[3].name = "sat";    tab[3].f = '{2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047};
    tab[3].exp  = '{SAT0, DC, DC, DC, DC, DC, DC, DC};
    tab[4].name = "f4_neg"; tab[4].f = '{0, 0, 0, 0, -200, 0, 0, 0};
    tab[4].exp  = '{DC, DC, DC, DC, DC, DC, DC, DC};
    z = '{0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_din_ready", int'(din_ready), 1);
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_dout_idx", int'(dout_idx), 0);
    check("rst_dout_last", int'(dout_last), 0);

    for (int i = 0; i < 5; i++) begin
      for (int x = 0; x < 8; x++) e[x] = (tab[i].exp[x] == DC) ? model(tab[i].f, x) : tab[i].exp[x];
      send_row(tab[i].f);
      recv_row(tab[i].name, e, 8, (i == 0) ? 2 : -1, 0);
    end

    for (int r = 0; r < 6; r++) begin
      for (int u = 0; u < 8; u++)
        f[u] = (r < 3) ? int'($urandom_range(80, 0)) - 40 : int'($urandom_range(4095, 0)) - 2048;
      for (int x = 0; x < 8; x++) e[x] = model(f, x);
      send_row(f);
      recv_row("rand", e, 8, (r == 4) ? 5 : -1, 2);
    end

    // Abort in the middle of the x=3 computation, then confirm a clean row has no residue.
    for (int u = 0; u < 8; u++) f[u] = int'($urandom_range(600, 0)) - 300;
    for (int x = 0; x < 8; x++) e[x] = model(f, x);
    send_row(f);
    recv_row("pre_rst", e, 3, -1, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_dout_valid", int'(dout_valid), 0);
    check("mid_rst_din_ready", int'(din_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    send_row(z);
    recv_row("post_rst", z, 8, -1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
